// File: rtl/anubis_pkg.sv
// Shared GF(2^8) arithmetic, Vandermonde coefficients and FSM encoding for the
// iterative Anubis key-selection stage.
package anubis_pkg;

  localparam logic [7:0] GF_POLY = 8'h1D;  // x^8 + x^4 + x^3 + x^2 + 1, low byte
  localparam int unsigned ROW_W = 4;       // row counter width, covers N <= 10

  typedef enum logic {
    StIdle,
    StAcc
  } state_e;

  function automatic logic [7:0] gf_mul2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = gf_mul2(x);
    end
    return p;
  endfunction

  // V[i][j] = 0x02^(i*j); largest exponent is 3*9 = 27 for N = 10.
  function automatic logic [7:0] vand(input logic [1:0] i, input logic [ROW_W-1:0] j);
    int unsigned e;
    logic [7:0]  v;
    e = 32'(i) * 32'(j);
    v = 8'h01;
    for (int unsigned k = 0; k < 27; k++) begin
      if (k < e) v = gf_mul2(v);
    end
    return v;
  endfunction

endpackage

// File: rtl/anubis_key_selection_iter_if.sv
// Load/result bundle between key evolution, key selection and the round-key file.
interface anubis_key_selection_iter_if #(
  parameter int unsigned KEY_WORDS = 4,
  parameter int unsigned CNT_W     = 4
);

  logic                    load_key;
  logic                    restart;
  logic [32*KEY_WORDS-1:0] evolutioned_key;
  logic [127:0]            round_key;
  logic                    key_valid;
  logic [CNT_W-1:0]        round_idx;
  logic                    busy;
  logic                    load_err;

  modport master (
    output load_key, restart, evolutioned_key,
    input  round_key, key_valid, round_idx, busy, load_err
  );

  modport slave (
    input  load_key, restart, evolutioned_key,
    output round_key, key_valid, round_idx, busy, load_err
  );

endinterface

// File: rtl/anubis_row_mac.sv
// One key row times one Vandermonde column: 16 GF(2^8) products, byte (i,c) =
// coef[i] * row[c], laid out as the 128-bit round key.
module anubis_row_mac
  import anubis_pkg::*;
(
  input  logic [31:0]      row_i,
  input  logic [3:0][7:0]  coef_i,
  output logic [127:0]     pp_o
);

  always_comb begin
    pp_o = '0;
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 4; c++) begin
        pp_o[127-8*(4*i+c) -: 8] = gf_mul(coef_i[i], row_i[31-8*c -: 8]);
      end
    end
  end

endmodule

// File: rtl/anubis_key_selection_iter.sv
// Iterative Anubis key selection: K^r = V * kappa^r, one key row per clock,
// with a wrapping round counter.
module anubis_key_selection_iter
  import anubis_pkg::*;
#(
  parameter int unsigned KEY_WORDS = 4,
  parameter int unsigned ROUNDS    = 12,
  parameter int unsigned CNT_W     = 4
) (
  input logic                        clk,
  input logic                        reset,
  anubis_key_selection_iter_if.slave bus
);

  localparam int unsigned KeyBits = 32 * KEY_WORDS;

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [KeyBits-1:0] key_q, key_d;
  logic [127:0]       acc_q, acc_d;
  logic [127:0]       round_key_q, round_key_d;
  logic               key_valid_q, key_valid_d;
  logic               load_err_q, load_err_d;
  logic [CNT_W-1:0]   round_idx_q, round_idx_d;
  logic               first_q, first_d;

  logic [3:0][7:0]    coef;
  logic [127:0]       pp;
  logic               last_row;

  // The current row always sits in the top word of the shift register.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      coef[i] = vand(2'(i), row_q);
    end
  end

  anubis_row_mac u_row_mac (
    .row_i  (key_q[KeyBits-1 -: 32]),
    .coef_i (coef),
    .pp_o   (pp)
  );

  assign last_row = (row_q == ROW_W'(KEY_WORDS - 1));

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    key_d       = key_q;
    acc_d       = acc_q;
    round_key_d = round_key_q;
    key_valid_d = 1'b0;
    load_err_d  = 1'b0;
    round_idx_d = round_idx_q;
    first_d     = first_q;

    unique case (state_q)
      StIdle: begin
        if (bus.load_key) begin
          key_d   = bus.evolutioned_key;
          acc_d   = '0;
          row_d   = '0;
          state_d = StAcc;
        end
      end
      StAcc: begin
        acc_d = acc_q ^ pp;
        row_d = row_q + ROW_W'(1);
        key_d = key_q << 32;
        if (bus.load_key) load_err_d = 1'b1;
        if (last_row) begin
          round_key_d = acc_q ^ pp;
          key_valid_d = 1'b1;
          state_d     = StIdle;
          // The first key after reset/restart keeps index 0.
          if (first_q) begin
            first_d = 1'b0;
          end else if (round_idx_q == CNT_W'(ROUNDS - 1)) begin
            round_idx_d = '0;
          end else begin
            round_idx_d = round_idx_q + CNT_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Completion only happens while busy, so an accepted restart never collides with it.
    if (bus.restart && (state_q == StIdle)) begin
      round_idx_d = '0;
      first_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      row_q       <= '0;
      key_q       <= '0;
      acc_q       <= '0;
      round_key_q <= '0;
      key_valid_q <= 1'b0;
      load_err_q  <= 1'b0;
      round_idx_q <= '0;
      first_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      key_q       <= key_d;
      acc_q       <= acc_d;
      round_key_q <= round_key_d;
      key_valid_q <= key_valid_d;
      load_err_q  <= load_err_d;
      round_idx_q <= round_idx_d;
      first_q     <= first_d;
    end
  end

  assign bus.round_key = round_key_q;
  assign bus.key_valid = key_valid_q;
  assign bus.round_idx = round_idx_q;
  assign bus.busy      = (state_q == StAcc);
  assign bus.load_err  = load_err_q;

endmodule

// File: tb/tb_anubis_key_selection_iter.sv
// Bench for anubis_key_selection_iter: an N=4 and an N=10 instance checked against
// a log/antilog GF(2^8) model of K = V * kappa.
module tb_anubis_key_selection_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4, rst10;
  int   errors = 0;
  int   checks = 0;
  int   cnt4   = 0;
  int   cnt10  = 0;
  int   exp_t [0:254];
  int   log_t [0:255];

  anubis_key_selection_iter_if #(.KEY_WORDS(4),  .CNT_W(4)) if4  ();
  anubis_key_selection_iter_if #(.KEY_WORDS(10), .CNT_W(5)) if10 ();

  anubis_key_selection_iter #(.KEY_WORDS(4), .ROUNDS(12), .CNT_W(4)) dut4 (
    .clk   (clk),
    .reset (rst4),
    .bus   (if4)
  );

  anubis_key_selection_iter #(.KEY_WORDS(10), .ROUNDS(18), .CNT_W(5)) dut10 (
    .clk   (clk),
    .reset (rst10),
    .bus   (if10)
  );

  task automatic build_tables();
    int e;
    e = 1;
    for (int k = 0; k < 255; k++) begin
      exp_t[k] = e;
      log_t[e] = k;
      e = e << 1;
      if ((e & 256) != 0) e = e ^ 'h11D;
    end
  endtask

  function automatic int gm(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return exp_t[(log_t[a] + log_t[b]) % 255];
  endfunction

  // Byte (i,c) = XOR over rows j of 2^(i*j) * kappa[j][c].
  function automatic logic [127:0] model_key(input logic [319:0] k, input int n);
    logic [127:0] r;
    int           acc;
    int           kb;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 4; c++) begin
        acc = 0;
        for (int j = 0; j < n; j++) begin
          kb  = int'(k[32*n-1-32*j-8*c -: 8]);
          acc = acc ^ gm(exp_t[(i*j) % 255], kb);
        end
        r[127-8*(4*i+c) -: 8] = 8'(acc);
      end
    end
    return r;
  endfunction

  task automatic run_key4(input logic [127:0] key, output logic [127:0] rk,
                          output logic [3:0] idx, output int lat);
    @(negedge clk);
    if4.evolutioned_key = key;
    if4.load_key = 1'b1;
    @(posedge clk);
    #1;
    if4.load_key = 1'b0;
    if4.evolutioned_key = {$urandom, $urandom, $urandom, $urandom};
    lat = -1;
    rk  = '0;
    idx = '0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (if4.key_valid) begin
        lat = n;
        rk  = if4.round_key;
        idx = if4.round_idx;
        break;
      end
    end
  endtask

  task automatic run_key10(input logic [319:0] key, output logic [127:0] rk,
                           output logic [4:0] idx, output int lat);
    logic [319:0] junk;
    @(negedge clk);
    if10.evolutioned_key = key;
    if10.load_key = 1'b1;
    @(posedge clk);
    #1;
    if10.load_key = 1'b0;
    for (int w = 0; w < 10; w++) junk[32*w +: 32] = $urandom;
    if10.evolutioned_key = junk;
    lat = -1;
    rk  = '0;
    idx = '0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      if (if10.key_valid) begin
        lat = n;
        rk  = if10.round_key;
        idx = if10.round_idx;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst4  = 1'b0;
    rst10 = 1'b0;
    #12;
    checks++; if (if4.round_key !== 128'h0) begin errors++;
      $display("FAIL reset4.round_key got %h want 0", if4.round_key); end
    checks++; if (if4.key_valid !== 1'b0) begin errors++;
      $display("FAIL reset4.key_valid got %b want 0", if4.key_valid); end
    checks++; if (if4.busy !== 1'b0) begin errors++;
      $display("FAIL reset4.busy got %b want 0", if4.busy); end
    checks++; if (if4.load_err !== 1'b0) begin errors++;
      $display("FAIL reset4.load_err got %b want 0", if4.load_err); end
    checks++; if (if4.round_idx !== 4'd0) begin errors++;
      $display("FAIL reset4.round_idx got %0d want 0", if4.round_idx); end
    checks++; if (if10.round_key !== 128'h0) begin errors++;
      $display("FAIL reset10.round_key got %h want 0", if10.round_key); end
    checks++; if (if10.busy !== 1'b0 || if10.key_valid !== 1'b0) begin errors++;
      $display("FAIL reset10.busy_valid got %b%b want 00", if10.busy, if10.key_valid); end
    @(negedge clk);
    rst4  = 1'b1;
    rst10 = 1'b1;
    cnt4  = 0;
    cnt10 = 0;
  endtask

  task automatic test_basic4();
    logic [127:0] keys [6];
    logic [127:0] lits [3];
    logic [127:0] rk;
    logic [127:0] want;
    logic [3:0]   idx;
    int           lat;
    keys[0] = 128'h01020304_00000000_00000000_00000000;
    keys[1] = 128'h00000000_01000000_00000000_00000000;
    keys[2] = 128'h00000000_00000000_00000000_80000000;
    lits[0] = 128'h01020304_01020304_01020304_01020304;
    lits[1] = 128'h01000000_02000000_04000000_08000000;
    lits[2] = 128'h80000000_74000000_87000000_4C000000;
    for (int v = 3; v < 6; v++) keys[v] = {$urandom, $urandom, $urandom, $urandom};
    for (int v = 0; v < 6; v++) begin
      run_key4(keys[v], rk, idx, lat);
      want = model_key({192'h0, keys[v]}, 4);
      checks++; if (lat !== 4) begin errors++;
        $display("FAIL basic4[%0d].latency got %0d want 4", v, lat); end
      checks++; if (rk !== want) begin errors++;
        $display("FAIL basic4[%0d].round_key got %h want %h", v, rk, want); end
      if (v < 3) begin
        checks++; if (rk !== lits[v]) begin errors++;
          $display("FAIL basic4[%0d].vector got %h want %h", v, rk, lits[v]); end
      end
      checks++; if (int'(idx) !== cnt4 % 12) begin errors++;
        $display("FAIL basic4[%0d].round_idx got %0d want %0d", v, idx, cnt4 % 12); end
      cnt4++;
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] key;
    logic [127:0] rk;
    logic [127:0] want;
    logic [3:0]   idx;
    int           lat;
    @(negedge clk);
    if4.restart = 1'b1;
    @(posedge clk);
    #1;
    if4.restart = 1'b0;
    cnt4 = 0;
    checks++; if (if4.round_idx !== 4'd0) begin errors++;
      $display("FAIL b2b.restart_idx got %0d want 0", if4.round_idx); end
    for (int k = 0; k < 13; k++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      run_key4(key, rk, idx, lat);
      want = model_key({192'h0, key}, 4);
      checks++; if (int'(idx) !== cnt4 % 12) begin errors++;
        $display("FAIL b2b[%0d].round_idx got %0d want %0d", k, idx, cnt4 % 12); end
      checks++; if (rk !== want || lat !== 4) begin errors++;
        $display("FAIL b2b[%0d].key got %h lat %0d want %h lat 4", k, rk, lat, want); end
      cnt4++;
    end
  endtask

  task automatic test_load_err();
    logic [127:0] key;
    logic [127:0] want;
    int           pulses;
    key  = {$urandom, $urandom, $urandom, $urandom};
    want = model_key({192'h0, key}, 4);
    @(negedge clk);
    if4.evolutioned_key = key;
    if4.load_key = 1'b1;
    @(posedge clk);
    #1;
    if4.load_key = 1'b0;
    checks++; if (if4.busy !== 1'b1) begin errors++;
      $display("FAIL lerr.busy got %b want 1", if4.busy); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    if4.load_key = 1'b1;
    @(posedge clk);
    #1;
    if4.load_key = 1'b0;
    checks++; if (if4.key_valid !== 1'b1 || if4.round_key !== want) begin errors++;
      $display("FAIL lerr.key got v=%b %h want v=1 %h", if4.key_valid, if4.round_key, want); end
    checks++; if (if4.load_err !== 1'b1) begin errors++;
      $display("FAIL lerr.pulse got %b want 1", if4.load_err); end
    checks++; if (int'(if4.round_idx) !== cnt4 % 12) begin errors++;
      $display("FAIL lerr.round_idx got %0d want %0d", if4.round_idx, cnt4 % 12); end
    cnt4++;
    pulses = 0;
    @(posedge clk);
    #1;
    checks++; if (if4.load_err !== 1'b0) begin errors++;
      $display("FAIL lerr.pulse_width got %b want 0", if4.load_err); end
    for (int n = 0; n < 8; n++) begin
      if (if4.key_valid) pulses++;
      @(posedge clk);
      #1;
    end
    checks++; if (pulses !== 0 || if4.busy !== 1'b0) begin errors++;
      $display("FAIL lerr.dropped got pulses=%0d busy=%b want 0 0", pulses, if4.busy); end
  endtask

  task automatic test_restart();
    logic [127:0] key;
    logic [127:0] rk;
    logic [3:0]   idx;
    int           lat;
    int           n;
    key = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    if4.evolutioned_key = key;
    if4.load_key = 1'b1;
    @(posedge clk);
    #1;
    if4.load_key = 1'b0;
    if4.restart  = 1'b1;
    n = 0;
    while (!if4.key_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if4.restart = 1'b0;
    checks++; if (if4.key_valid !== 1'b1 || int'(if4.round_idx) !== cnt4 % 12) begin errors++;
      $display("FAIL rst_busy.round_idx got v=%b %0d want v=1 %0d",
               if4.key_valid, if4.round_idx, cnt4 % 12); end
    cnt4++;
    // key_valid is high in this cycle; restart here must still zero the counter.
    if4.restart = 1'b1;
    @(posedge clk);
    #1;
    if4.restart = 1'b0;
    cnt4 = 0;
    checks++; if (if4.round_idx !== 4'd0) begin errors++;
      $display("FAIL rst_valid.round_idx got %0d want 0", if4.round_idx); end
    for (int k = 0; k < 2; k++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      run_key4(key, rk, idx, lat);
      checks++; if (int'(idx) !== cnt4 || rk !== model_key({192'h0, key}, 4)) begin errors++;
        $display("FAIL rst_after[%0d] got idx %0d key %h want idx %0d", k, idx, rk, cnt4); end
      cnt4++;
    end
  endtask

  task automatic test_n10();
    logic [319:0] key;
    logic [127:0] rk;
    logic [127:0] want;
    logic [4:0]   idx;
    int           lat;
    int           pulses;
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 10; w++) key[32*w +: 32] = $urandom;
      run_key10(key, rk, idx, lat);
      want = model_key(key, 10);
      checks++; if (rk !== want) begin errors++;
        $display("FAIL n10[%0d].round_key got %h want %h", k, rk, want); end
      checks++; if (lat !== 10) begin errors++;
        $display("FAIL n10[%0d].latency got %0d want 10", k, lat); end
      checks++; if (int'(idx) !== cnt10 % 18) begin errors++;
        $display("FAIL n10[%0d].round_idx got %0d want %0d", k, idx, cnt10 % 18); end
      cnt10++;
    end
    // Reset while accumulating.
    for (int w = 0; w < 10; w++) key[32*w +: 32] = $urandom;
    @(negedge clk);
    if10.evolutioned_key = key;
    if10.load_key = 1'b1;
    @(posedge clk);
    #1;
    if10.load_key = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst10 = 1'b0;
    #1;
    checks++; if (if10.busy !== 1'b0 || if10.round_key !== 128'h0) begin errors++;
      $display("FAIL n10_abort.state got busy=%b key=%h want 0 0", if10.busy, if10.round_key); end
    checks++; if (if10.round_idx !== 5'd0) begin errors++;
      $display("FAIL n10_abort.round_idx got %0d want 0", if10.round_idx); end
    pulses = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (if10.key_valid) pulses++;
    end
    @(negedge clk);
    rst10 = 1'b1;
    cnt10 = 0;
    for (int n = 0; n < 14; n++) begin
      @(posedge clk);
      #1;
      if (if10.key_valid) pulses++;
    end
    checks++; if (pulses !== 0 || if10.busy !== 1'b0) begin errors++;
      $display("FAIL n10_abort.no_valid got pulses=%0d busy=%b want 0 0", pulses, if10.busy); end
    for (int w = 0; w < 10; w++) key[32*w +: 32] = $urandom;
    run_key10(key, rk, idx, lat);
    want = model_key(key, 10);
    checks++; if (rk !== want || lat !== 10) begin errors++;
      $display("FAIL n10_reload.key got %h lat %0d want %h lat 10", rk, lat, want); end
    checks++; if (idx !== 5'd0) begin errors++;
      $display("FAIL n10_reload.round_idx got %0d want 0", idx); end
    cnt10++;
  endtask

  initial begin
    if4.load_key         = 1'b0;
    if4.restart          = 1'b0;
    if4.evolutioned_key  = '0;
    if10.load_key        = 1'b0;
    if10.restart         = 1'b0;
    if10.evolutioned_key = '0;
    build_tables();
    test_reset();
    test_basic4();
    test_back_to_back();
    test_load_err();
    test_restart();
    test_n10();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
